// File: rtl/jtag_tap_multi_if.sv
// JTAG serial pins of the test-access block: host drives tms/tdi, the TAP returns
// tdo and its enable.
interface jtag_tap_multi_if;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_en;

  modport master (output tms, output tdi, input tdo, input tdo_en);
  modport slave  (input tms, input tdi, output tdo, output tdo_en);
endinterface

// File: rtl/jtag_tap_multi.sv
// IEEE 1149.1 TAP with configurable IR, bypass, IDCODE, external BSR strobes and
// NUM_USER user data registers with parallel capture/update ports.
module jtag_tap_multi #(
  parameter int          IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
  parameter int          NUM_USER     = 2,
  parameter int          USER_WIDTH   = 16
) (
  input  logic                           tck,
  input  logic                           trst,
  jtag_tap_multi_if.slave                jtag,
  output logic [IR_WIDTH-1:0]            ir_out,
  output logic                           bsr_capture,
  output logic                           bsr_shift,
  output logic                           bsr_update,
  output logic                           bsr_mode,
  output logic                           bsr_tdi,
  input  logic                           bsr_tdo,
  input  logic [NUM_USER*USER_WIDTH-1:0] user_capture_data,
  output logic [NUM_USER*USER_WIDTH-1:0] user_update_data,
  output logic [NUM_USER-1:0]            user_update_strobe
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] OP_EXTEST = '0;
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;

  tap_state_t            state;
  tap_state_t            state_nxt;
  logic [IR_WIDTH-1:0]   ir_sr;
  logic                  bypass_sr;
  logic [31:0]           idcode_sr;
  logic [USER_WIDTH-1:0] user_sr [NUM_USER];
  logic [NUM_USER-1:0]   user_hit;
  logic                  sel_idcode;
  logic                  sel_bsr;
  logic                  sel_user;
  logic                  user_lsb;
  logic                  tdo_p0;
  logic                  tdo_en_p0;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic t);
    case (s)
      TLR:     return t ? TLR    : RTI;
      RTI:     return t ? SEL_DR : RTI;
      SEL_DR:  return t ? SEL_IR : CAP_DR;
      CAP_DR:  return t ? EX1_DR : SH_DR;
      SH_DR:   return t ? EX1_DR : SH_DR;
      EX1_DR:  return t ? UPD_DR : PAU_DR;
      PAU_DR:  return t ? EX2_DR : PAU_DR;
      EX2_DR:  return t ? UPD_DR : SH_DR;
      UPD_DR:  return t ? SEL_DR : RTI;
      SEL_IR:  return t ? TLR    : CAP_IR;
      CAP_IR:  return t ? EX1_IR : SH_IR;
      SH_IR:   return t ? EX1_IR : SH_IR;
      EX1_IR:  return t ? UPD_IR : PAU_IR;
      PAU_IR:  return t ? EX2_IR : PAU_IR;
      EX2_IR:  return t ? UPD_IR : SH_IR;
      UPD_IR:  return t ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  // Right shift with the new bit entering the MSB; also correct for 1-bit registers.
  function automatic logic [USER_WIDTH-1:0] shr_user(input logic [USER_WIDTH-1:0] v,
                                                     input logic b);
    logic [USER_WIDTH-1:0] r;
    r = v >> 1;
    r[USER_WIDTH-1] = b;
    return r;
  endfunction

  assign state_nxt = tap_next(state, jtag.tms);
  assign bsr_tdi   = jtag.tdi;
  assign bsr_mode  = (ir_out == OP_EXTEST);

  // All-ones stays BYPASS even where a USER opcode would alias it.
  always_comb begin
    user_hit = '0;
    user_lsb = 1'b0;
    for (int k = 0; k < NUM_USER; k++) begin
      if (((8 + k) < (1 << IR_WIDTH)) && (ir_out != OP_BYPASS) && (ir_out == IR_WIDTH'(8 + k)))
        user_hit[k] = 1'b1;
      user_lsb = user_lsb | (user_hit[k] & user_sr[k][0]);
    end
    sel_idcode = (ir_out == OP_IDCODE);
    sel_bsr    = (ir_out == OP_EXTEST) || (ir_out == OP_SAMPLE);
    sel_user   = |user_hit;
  end

  always_comb begin
    tdo_p0    = 1'b0;
    tdo_en_p0 = (state == SH_IR) || (state == SH_DR);
    if (state == SH_IR)
      tdo_p0 = ir_sr[0];
    else if (state == SH_DR) begin
      if (sel_bsr)         tdo_p0 = bsr_tdo;
      else if (sel_idcode) tdo_p0 = idcode_sr[0];
      else if (sel_user)   tdo_p0 = user_lsb;
      else                 tdo_p0 = bypass_sr;
    end
  end

  // ---- rising edge: TAP state, shift registers, strobes ----
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state              <= TLR;
      ir_sr              <= '0;
      ir_out             <= OP_IDCODE;
      bypass_sr          <= 1'b0;
      idcode_sr          <= '0;
      for (int k = 0; k < NUM_USER; k++) user_sr[k] <= '0;
      user_update_data   <= '0;
      user_update_strobe <= '0;
      bsr_capture        <= 1'b0;
      bsr_shift          <= 1'b0;
      bsr_update         <= 1'b0;
    end else begin
      state              <= state_nxt;
      bsr_capture        <= sel_bsr && (state_nxt == CAP_DR);
      bsr_shift          <= sel_bsr && (state_nxt == SH_DR);
      bsr_update         <= sel_bsr && (state_nxt == UPD_DR);
      user_update_strobe <= '0;
      case (state)
        CAP_IR: ir_sr <= IR_WIDTH'(1);
        SH_IR:  ir_sr <= {jtag.tdi, ir_sr[IR_WIDTH-1:1]};
        UPD_IR: ir_out <= ir_sr;
        CAP_DR: begin
          bypass_sr <= 1'b0;
          if (sel_idcode) idcode_sr <= IDCODE_VALUE | 32'd1;
          for (int k = 0; k < NUM_USER; k++)
            if (user_hit[k]) user_sr[k] <= user_capture_data[k*USER_WIDTH +: USER_WIDTH];
        end
        SH_DR: begin
          bypass_sr <= jtag.tdi;
          if (sel_idcode) idcode_sr <= {jtag.tdi, idcode_sr[31:1]};
          for (int k = 0; k < NUM_USER; k++)
            if (user_hit[k]) user_sr[k] <= shr_user(user_sr[k], jtag.tdi);
        end
        UPD_DR: begin
          for (int k = 0; k < NUM_USER; k++)
            if (user_hit[k]) begin
              user_update_data[k*USER_WIDTH +: USER_WIDTH] <= user_sr[k];
              user_update_strobe[k] <= 1'b1;
            end
        end
        default: ;
      endcase
      if (state_nxt == TLR) ir_out <= OP_IDCODE;
    end
  end

  // ---- falling edge: tdo retiming ----
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      jtag.tdo    <= 1'b0;
      jtag.tdo_en <= 1'b0;
    end else begin
      jtag.tdo    <= tdo_p0;
      jtag.tdo_en <= tdo_en_p0;
    end
  end

endmodule

// File: tb/tb_jtag_tap_multi.sv
// Self-checking bench for jtag_tap_multi: table of IR/DR scans plus hand-written
// pause, five-tms-escape and mid-scan reset sequences; tdo checked via a queue.
module tb_jtag_tap_multi;

  logic        tck = 1'b0;
  logic        trst;
  logic [3:0]  ir_out;
  logic        bsr_capture, bsr_shift, bsr_update, bsr_mode, bsr_tdi, bsr_tdo;
  logic [31:0] user_capture_data;
  logic [31:0] user_update_data;
  logic [1:0]  user_update_strobe;

  jtag_tap_multi_if jif ();

  jtag_tap_multi #(
    .IR_WIDTH(4), .IDCODE_VALUE(32'h1000_0001), .NUM_USER(2), .USER_WIDTH(16)
  ) dut (
    .tck(tck), .trst(trst), .jtag(jif), .ir_out(ir_out),
    .bsr_capture(bsr_capture), .bsr_shift(bsr_shift), .bsr_update(bsr_update),
    .bsr_mode(bsr_mode), .bsr_tdi(bsr_tdi), .bsr_tdo(bsr_tdo),
    .user_capture_data(user_capture_data), .user_update_data(user_update_data),
    .user_update_strobe(user_update_strobe)
  );

  always #5 tck = ~tck;

  // External 8-bit boundary-scan chain driven by the strobes; captures a fixed pattern.
  logic [7:0] bsr_sr  = 8'h00;
  logic [7:0] bsr_upd = 8'h00;
  assign bsr_tdo = bsr_sr[0];
  always @(posedge tck) begin
    if (bsr_capture)    bsr_sr <= 8'h3C;
    else if (bsr_shift) bsr_sr <= {bsr_tdi, bsr_sr[7:1]};
    if (bsr_update)     bsr_upd <= bsr_sr;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  typedef struct { logic en; logic d; } exp_t;
  exp_t exp_q[$];

  // Scoreboard: each driven step may push the tdo/tdo_en expected after its falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge tck);
      #1;
      if (jif.tdo_en === 1'b1) en_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tdo", {jif.tdo_en, jif.tdo}, {e.en, e.d});
      end
    end
  end

  task automatic step(input logic t, input logic d, input bit chk, input logic ee, input logic ed);
    exp_t e;
    jif.tms = t;
    jif.tdi = d;
    if (chk) begin
      e.en = ee;
      e.d  = ed;
      exp_q.push_back(e);
    end
    @(posedge tck);
    @(negedge tck);
    #2;
  endtask

  // Shift bits lo..lo+n-1 of din; the last one leaves the shift state.
  task automatic shift_seg(input logic [31:0] din, input logic [31:0] dexp, input int lo, input int n);
    for (int i = lo; i < lo + n; i++) begin
      if (i == lo + n - 1) step(1'b1, din[i], 1, 1'b0, 1'b0);
      else                 step(1'b0, din[i], 1, 1'b1, dexp[i+1]);
    end
  endtask

  task automatic ir_scan(input logic [3:0] val);
    logic [31:0] cap;
    cap = 32'h1;
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1, 1'b1, cap[0]);
    shift_seg({28'h0, val}, cap, 0, 4);
    step(1'b1, 1'b0, 1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1, 1'b0, 1'b0);
  endtask

  task automatic dr_scan(input logic [31:0] din, input logic [31:0] dexp, input int len);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1, 1'b1, dexp[0]);
    shift_seg(din, dexp, 0, len);
    step(1'b1, 1'b0, 1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit          do_ir;
    logic [3:0]  ir;
    int          len;
    logic [31:0] cap;
    logic [31:0] din;
    logic [31:0] dexp;
    logic [31:0] upd;
    logic [1:0]  strb;
    logic        mode;
    bit          is_bsr;
    logic [7:0]  bupd;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en0;
    logic [31:0] d16;
    tbl[0] = '{1'b0, 4'h1, 32, 32'h0, 32'h0, 32'h1000_0001, 32'h0, 2'b00, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 4'hF,  8, 32'h0, 32'hA5, 32'h4A, 32'h0, 2'b00, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 4'h5,  4, 32'h0, 32'hB, 32'h6, 32'h0, 2'b00, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 4'h8, 16, 32'h5678_1234, 32'hBEEF, 32'h1234, 32'h0000_BEEF, 2'b01, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 4'h9, 16, 32'h5678_1234, 32'h0F0F, 32'h5678, 32'h0F0F_BEEF, 2'b10, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 4'h2,  8, 32'h0, 32'h96, 32'h3C, 32'h0F0F_BEEF, 2'b00, 1'b0, 1'b1, 8'h96};
    tbl[6] = '{1'b1, 4'h0,  8, 32'h0, 32'h81, 32'h3C, 32'h0F0F_BEEF, 2'b00, 1'b1, 1'b1, 8'h81};
    tbl[7] = '{1'b1, 4'hE,  3, 32'h0, 32'h5, 32'h2, 32'h0F0F_BEEF, 2'b00, 1'b0, 1'b0, 8'h00};

    jif.tms = 1'b1;
    jif.tdi = 1'b0;
    trst = 1'b0;
    user_capture_data = 32'h0;
    @(negedge tck);
    #2;
    check("rst_tdo", {jif.tdo_en, jif.tdo}, 2'b00);
    check("rst_ir_out", ir_out, 4'h1);
    check("rst_user_data", user_update_data, 32'h0);
    check("rst_strobe", user_update_strobe, 2'b00);
    check("rst_bsr", {bsr_mode, bsr_capture, bsr_shift, bsr_update}, 4'b0000);
    trst = 1'b1;
    step(1'b0, 1'b0, 1, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      if (tbl[r].do_ir) ir_scan(tbl[r].ir);
      check("ir_out", ir_out, tbl[r].ir);
      user_capture_data = tbl[r].cap;
      en0 = en_cnt;
      dr_scan(tbl[r].din, tbl[r].dexp, tbl[r].len);
      check("tdo_en_count", en_cnt - en0, tbl[r].len);
      check("upd_strobe", user_update_strobe, tbl[r].strb);
      check("user_data", user_update_data, tbl[r].upd);
      check("bsr_mode", bsr_mode, tbl[r].mode);
      if (tbl[r].is_bsr) check("bsr_chain_update", bsr_upd, tbl[r].bupd);
      step(1'b0, 1'b0, 0, 1'b0, 1'b0);
      check("strobe_one_cycle", user_update_strobe, 2'b00);
    end

    // Pause mid-scan; capture input changes while paused and must not be recaptured.
    ir_scan(4'h8);
    user_capture_data = 32'h5678_CAFE;
    d16 = 32'h3C5A;
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1, 1'b1, 1'b0);
    user_capture_data = 32'hFFFF_FFFF;
    shift_seg(d16, 32'hCAFE, 0, 8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1, 1'b1, 1'b0);
    shift_seg(d16, 32'hCAFE, 8, 8);
    step(1'b1, 1'b0, 1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1, 1'b0, 1'b0);
    check("pause_user_data", user_update_data, 32'h0F0F_3C5A);
    check("pause_strobe", user_update_strobe, 2'b01);

    // Five tms=1 from ShDR under EXTEST.
    ir_scan(4'h0);
    check("extest_mode", bsr_mode, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1, 1'b0, 1'b0);
    check("tlr_ir_out", ir_out, 4'h1);
    check("tlr_bsr_mode", bsr_mode, 1'b0);
    check("tlr_user_kept", user_update_data, 32'h0F0F_3C5A);

    // Asynchronous reset in the middle of a USER1 shift.
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    ir_scan(4'h9);
    user_capture_data = 32'h5678_1234;
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1, 1'b1, 1'b0);
    d16 = 32'h5678;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1, 1'b1, d16[i+1]);
    trst = 1'b0;
    #1;
    check("trst_tdo", {jif.tdo_en, jif.tdo}, 2'b00);
    check("trst_ir_out", ir_out, 4'h1);
    check("trst_user_data", user_update_data, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 0, 1'b0, 1'b0);
      check("trst_no_strobe", user_update_strobe, 2'b00);
    end
    trst = 1'b1;
    step(1'b0, 1'b0, 1, 1'b0, 1'b0);
    check("post_trst_strobe", user_update_strobe, 2'b00);
    check("post_trst_ir_out", ir_out, 4'h1);
    check("post_trst_user", user_update_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
